// File: rtl/core_sequencer.sv
// Multi-cycle core control sequencer: walks each instruction through
// FETCH -> DECODE -> EXEC -> [MEM] -> WB and counts retired instructions.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   FETCH  | request instruction word, load IR when it arrives
//   DECODE | one idle cycle while the decoder settles on the new IR
//   EXEC   | ALU cycle; choose MEM for loads/stores, else WB
//   MEM    | hold data request until dmem_ready
//   WB     | commit: PC update, register write, retire pulse
//   5..7   | illegal, all outputs low, recover to FETCH

module core_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic        ir_w,
    input  logic        jump,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic        reg_w,
    input  logic        data_r,
    input  logic        data_w,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pc_w,
    output logic        pc_sel,
    output logic        rf_w,
    output logic        retire,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    state_e      state_q;
    logic [31:0] instret_q;

    // Controls depend on same-cycle handshakes and reset, so they are decoded
    // from the registered state rather than registered themselves.
    always_comb begin
        imem_req = 1'b0;
        ir_w     = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_w     = 1'b0;
        pc_sel   = 1'b0;
        rf_w     = 1'b0;
        retire   = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    imem_req = !halt;
                    ir_w     = !halt && imem_ready;
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = data_w;
                end
                WB: begin
                    pc_w   = 1'b1;
                    pc_sel = jump | (branch & branch_taken);
                    rf_w   = reg_w & !data_w & !branch;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            instret_q <= 32'd0;
        end else begin
            case (state_q)
                FETCH:   if (ir_w) state_q <= DECODE;
                DECODE:  state_q <= EXEC;
                EXEC:    state_q <= (data_r | data_w) ? MEM : WB;
                MEM:     if (dmem_ready) state_q <= WB;
                WB:      state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign state   = state_q;
    assign instret = reset ? 32'd0 : instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.

module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset, halt, imem_ready, imem_req, ir_w;
    logic        jump, branch, branch_taken, reg_w, data_r, data_w;
    logic        dmem_ready, dmem_req, dmem_we, pc_w, pc_sel, rf_w, retire;
    logic [2:0]  state;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_err = 0;

    core_sequencer dut (
        .clk(clk), .reset(reset), .halt(halt), .imem_ready(imem_ready),
        .imem_req(imem_req), .ir_w(ir_w), .jump(jump), .branch(branch),
        .branch_taken(branch_taken), .reg_w(reg_w), .data_r(data_r),
        .data_w(data_w), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .pc_w(pc_w), .pc_sel(pc_sel), .rf_w(rf_w),
        .retire(retire), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // outs = {imem_req, ir_w, dmem_req, dmem_we, pc_w, pc_sel, rf_w, retire}
    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [7:0] outs);
        check(tag, {21'd0, state, imem_req, ir_w, dmem_req, dmem_we, pc_w, pc_sel, rf_w, retire},
              {21'd0, st, outs});
    endtask

    task automatic set_dec(input logic j, input logic b, input logic bt,
                           input logic rw, input logic dr, input logic dw);
        jump = j; branch = b; branch_taken = bt; reg_w = rw; data_r = dr; data_w = dw;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Called in a FETCH cycle with ir_w=1; ends in the following FETCH cycle.
    task automatic run_instr(input string tag, input logic mem, input logic we,
                             input int waits, input logic [7:0] wb_outs,
                             input logic [31:0] exp_instret);
        tick(); expect_cyc({tag, "_dec"}, 3'd1, 8'b0000_0000);
        dmem_ready = 1'b1;
        tick(); expect_cyc({tag, "_exec"}, 3'd2, 8'b0000_0000);
        if (mem) begin
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                dmem_ready = (w == waits);
                #1;
                expect_cyc({tag, "_mem"}, 3'd3, {2'b00, 1'b1, we, 4'b0000});
            end
        end
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        expect_cyc({tag, "_wb"}, 3'd4, wb_outs);
        check({tag, "_wb_instret"}, instret, exp_instret - 32'd1);
        tick(); expect_cyc({tag, "_fetch"}, 3'd0, 8'b1100_0000);
        check({tag, "_instret"}, instret, exp_instret);
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        set_dec(0, 0, 0, 0, 0, 0);

        tick();
        expect_cyc("reset_outs", 3'd0, 8'b0000_0000);
        check("reset_instret", instret, 32'd0);
        reset = 1'b0;
        #1;
        expect_cyc("post_reset_fetch", 3'd0, 8'b1100_0000);

        // Three back-to-back ADDs, 4 cycles each
        set_dec(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            run_instr("add", 1'b0, 1'b0, 0, 8'b0000_1011, 32'(i + 1));

        // Load with 2 wait states, store, and simultaneous read+write
        set_dec(0, 0, 0, 1, 1, 0);
        run_instr("load", 1'b1, 1'b0, 2, 8'b0000_1011, 32'd4);
        set_dec(0, 0, 0, 0, 0, 1);
        run_instr("store", 1'b1, 1'b1, 0, 8'b0000_1001, 32'd5);
        set_dec(0, 0, 0, 1, 1, 1);
        run_instr("rdwr", 1'b1, 1'b1, 1, 8'b0000_1001, 32'd6);

        // Control flow
        set_dec(0, 1, 1, 1, 0, 0);
        run_instr("br_taken", 1'b0, 1'b0, 0, 8'b0000_1101, 32'd7);
        set_dec(0, 1, 0, 1, 0, 0);
        run_instr("br_not", 1'b0, 1'b0, 0, 8'b0000_1001, 32'd8);
        set_dec(1, 0, 0, 1, 0, 0);
        run_instr("jal", 1'b0, 1'b0, 0, 8'b0000_1111, 32'd9);

        // halt in FETCH parks the core
        halt = 1'b1;
        #1;
        expect_cyc("halt_fetch", 3'd0, 8'b0000_0000);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_cyc("halt_park", 3'd0, 8'b0000_0000);
        end
        halt = 1'b0;
        #1;
        expect_cyc("unhalt", 3'd0, 8'b1100_0000);

        // halt raised in EXEC: instruction still retires, then park
        set_dec(0, 0, 0, 1, 0, 0);
        tick(); expect_cyc("hx_dec", 3'd1, 8'b0000_0000);
        @(negedge clk); halt = 1'b1; #1;
        expect_cyc("hx_exec", 3'd2, 8'b0000_0000);
        tick(); expect_cyc("hx_wb", 3'd4, 8'b0000_1011);
        tick(); expect_cyc("hx_park", 3'd0, 8'b0000_0000);
        check("hx_instret", instret, 32'd10);
        tick(); expect_cyc("hx_park2", 3'd0, 8'b0000_0000);
        halt = 1'b0;
        #1;
        expect_cyc("hx_resume", 3'd0, 8'b1100_0000);

        // Reset during a MEM wait abandons the load
        set_dec(0, 0, 0, 1, 1, 0);
        tick(); expect_cyc("rm_dec", 3'd1, 8'b0000_0000);
        tick(); expect_cyc("rm_exec", 3'd2, 8'b0000_0000);
        @(negedge clk); dmem_ready = 1'b0; #1;
        expect_cyc("rm_mem", 3'd3, 8'b0010_0000);
        @(negedge clk); reset = 1'b1; #1;
        expect_cyc("rm_reset", 3'd3, 8'b0000_0000);
        check("rm_reset_instret", instret, 32'd0);
        @(negedge clk); reset = 1'b0; dmem_ready = 1'b1; #1;
        expect_cyc("rm_after", 3'd0, 8'b1100_0000);
        check("rm_after_instret", instret, 32'd0);

        // Counter wrap: preload the retire counter to all-ones
        dut.instret_q = 32'hFFFF_FFFF;
        #1;
        check("wrap_preload", instret, 32'hFFFF_FFFF);
        set_dec(0, 0, 0, 1, 0, 0);
        run_instr("wrap", 1'b0, 1'b0, 0, 8'b0000_1011, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL provide these ports, clock and reset first; one clock, reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- halt  in  1  hold the core at the fetch boundary
- imem_ready  in  1  instruction word valid this cycle
- imem_req  out  1  instruction fetch request
- ir_w  out  1  load the instruction register
- jump  in  1  decoder: JAL-class instruction
- branch  in  1  decoder: conditional branch
- branch_taken  in  1  ALU comparison result for the branch
- reg_w  in  1  decoder: write rd
- data_r  in  1  decoder: load
- data_w  in  1  decoder: store
- dmem_ready  in  1  data access complete this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  data access is a write
- pc_w  out  1  update PC
- pc_sel  out  1  0 = PC+4, 1 = datapath target
- rf_w  out  1  register file write enable
- retire  out  1  one-cycle pulse per completed instruction
- state  out  3  current state code, for debug
- instret  out  32  retired-instruction counter

Function
REQ-002 SHALL implement the FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next cycle with all outputs at 0.
REQ-003 FETCH: imem_req = !halt; ir_w = imem_req & imem_ready; go to DECODE when ir_w=1, otherwise stay in FETCH.
REQ-004 halt SHALL be honoured only in FETCH; an instruction already past FETCH SHALL run to WB.
REQ-005 DECODE SHALL last exactly 1 cycle, then go to EXEC; no outputs are asserted.
REQ-006 EXEC SHALL last 1 cycle; go to MEM if data_r|data_w, otherwise go to WB.
REQ-007 MEM: dmem_req=1; dmem_we=data_w; stay in MEM until dmem_ready=1, then go to WB; dmem_ready outside MEM SHALL be ignored.
REQ-008 WB SHALL last 1 cycle and then go to FETCH, with:
- pc_w=1
- pc_sel = jump | (branch & branch_taken)
- rf_w = reg_w & !data_w & !branch
- retire=1
REQ-009 If data_r and data_w are both 1, the access SHALL be a write (dmem_we=1) and rf_w SHALL be 0.
REQ-010 Decoder inputs SHALL be sampled only in EXEC, MEM and WB (the instruction register is stable there); they are don't-care in FETCH and DECODE.
REQ-011 Outputs imem_req, ir_w, dmem_req, dmem_we, pc_w, pc_sel, rf_w and retire SHALL be 0 in every state where they are not stated above.
REQ-012 instret SHALL increment by 1 on each cycle in which retire=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-013 Latency with zero wait states, counted from the FETCH cycle with imem_ready=1 through WB inclusive:
- non-memory instruction: 4 cycles
- load/store: 5 cycles
Each extra cycle with imem_ready or dmem_ready low adds exactly 1 cycle.
REQ-014 state SHALL equal the current FSM state code.

Reset
REQ-015 While reset=1 at a rising edge, the next state SHALL be FETCH and instret SHALL be 0.
REQ-016 While reset=1, all outputs except state SHALL be forced to 0, including imem_req.
REQ-017 Reset asserted mid-instruction (any state, including a MEM wait) SHALL abandon the instruction:
- no pc_w, rf_w or retire is issued for it
- dmem_req drops in the same cycle reset is high
REQ-018 On the first cycle after reset deasserts, the FSM SHALL be in FETCH with imem_req = !halt.

Verification
REQ-019 ADD-type (reg_w=1), imem_ready held 1: states 0,1,2,4 repeat; retire every 4th cycle; after 3 instructions instret=3, and rf_w=1, pc_sel=0 in each WB.
REQ-020 Load (data_r=1, reg_w=1), dmem_ready low for 2 MEM cycles then high: dmem_req high for 3 cycles with dmem_we=0; WB has rf_w=1; total latency 7 cycles.
REQ-021 Store (data_w=1, reg_w=0): dmem_we=1 throughout MEM; WB has rf_w=0, pc_w=1.
REQ-022 Branch with branch_taken=1 gives pc_sel=1 and rf_w=0 in WB; with branch_taken=0, pc_sel=0; JAL (jump=1, reg_w=1) gives pc_sel=1 and rf_w=1.
REQ-023 halt=1 in FETCH: imem_req=0 and state stays 0 indefinitely; halt raised during EXEC: the instruction still retires, then the FSM parks in FETCH.
REQ-024 Reset pulsed during a MEM wait: the next cycle has state=0, instret=0, and no retire or rf_w pulse; instret preloaded by 0xFFFFFFFF retirements wraps to 0 on the next retire.
